fsquare_iter: RTL and testbench
===============================

# fsquare_iter

Iterative single-precision floating-point squarer, s = d × d. It is the inverse-direction companion of the Newton square-root unit and sits in the same FPU execution slot. It uses the same start/busy/stall/enable pipeline handshake, so the integer pipeline stalls it identically. The mantissa square is formed by a radix-4 sequential multiplier over 12 iterations, followed by one normalize/round cycle.

## Interface
- No parameters.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- d  in  32  IEEE-754 single operand.
- rm  in  2  rounding mode:
  - 00 nearest-even
  - 01 toward −∞
  - 10 toward +∞
  - 11 toward zero
- fsquare  in  1  start request.
- enable  in  1  pipeline advance; when low, all state freezes.
- s  out  32  result register.
- busy  out  1  iteration in progress.
- stall  out  1  stall to the pipeline, defined as fsquare & busy (combinational).
- count  out  5  remaining multiply iterations.

## Operation
- **Accept:**
  - Condition: fsquare & enable & ~busy at a rising edge.
  - Captured: rm, special flags (NaN, inf, zero), and the normalized 24-bit mantissa m.
  - Denormal inputs are left-shifted until the MSB is set; the shift amount is subtracted from the exponent.
  - Unbiased exponent e is held as a 10-bit signed value.
  - Load count=12, set busy=1, clear the 48-bit accumulator.
- **Iterate** (busy & enable & count≠0):
  - acc += m × (multiplier bits [1:0]) << 2k.
  - Multiplier shifts right by 2; count decrements.
- **Finish** (busy & enable & count==0):
  - The 48-bit product lies in [1,4). If bit 47 is set, take the upper bits directly and add 1 to the exponent; otherwise shift left by 1.
  - Biased exponent E = 2e + 127 (+1 if normalized up).
  - Guard/round/sticky come from the discarded bits. Rounding is applied, and a mantissa carry-out increments E.
  - Result sign is always 0.
  - Underflow (E ≤ 0): right-shift the mantissa by 1−E, with shifted-out bits ORed into sticky, then round. A shift > 25 yields zero before rounding. rm=10 with nonzero sticky gives 0x00000001.
  - Overflow (E ≥ 255):
    - rm=00 or 10 → INF 0x7f800000.
    - rm=01 or 11 → MAX 0x7f7fffff.
  - Write s, clear busy.
- **Specials** (take the full latency, same timing):
  - NaN → 0x7fc00000.
  - ±inf → 0x7f800000.
  - ±0 → 0x00000000.
- fsquare while busy: ignored; stall=1 until busy falls. The held request is accepted on the first edge with busy=0.

## Timing
- Reset values: s=0, busy=0, count=0, stall=0.
- Reset mid-operation aborts the operation; s is cleared and no result is produced.
- Accept edge at cycle T:
  - busy=1 during cycles T+1 … T+13.
  - count reads 12 at T+1, down to 0 at T+13.
  - s is updated at the end of T+13; busy=0 and s valid from T+14.
  - Latency 14 cycles with enable held high.
- Each enable-low cycle extends the latency by one. While enable is low, count, acc, s and busy hold.
- s holds its value until the next Finish.
- A back-to-back request is accepted at the earliest edge ending cycle T+14, since busy=0 at that edge.

## Structure
- Shared package fp_pkg contains:
  - constants ZERO, INF=0x7f800000, NaN=0x7fc00000, MAX=0x7f7fffff;
  - rounding-mode encodings RM_RNE/RM_RDN/RM_RUP/RM_RTZ;
  - the round-increment function shared with the sqrt and adder units.
- Sub-module square24_radix4: owns acc, count and the multiplier shift register. It exposes start, enable, product[47:0], count and busy.
- Top level: operand unpack and leading-zero normalize, exponent arithmetic, normalize/round/special-case mux, and the s register.

## Test plan
- 0x3fc00000 (1.5), rm=00 → s=0x40100000 (2.25) at T+14. busy high T+1..T+13; count 12→0.
- 0x3f800001:
  - rm=00 → 0x3f800002.
  - rm=10 → 0x3f800003.
  - rm=11 → 0x3f800002.
- 0xc0400000 (−3.0) → 0x41100000. Also, 0x1f800000 (2^−64) → 0x00200000 (denormal).
- 0x7f7fffff:
  - rm=00 → 0x7f800000.
  - rm=11 → 0x7f7fffff.
- 0x00000001:
  - rm=00 → 0x00000000.
  - rm=10 → 0x00000001.
- Specials:
  - 0xffc00000 → 0x7fc00000.
  - 0xff800000 → 0x7f800000.
  - 0x80000000 → 0x00000000.
- Handshake:
  - fsquare held during busy → stall=1, second op accepted at T+14.
  - enable low for 3 cycles at T+5 → count frozen, result at T+17.
  - reset at T+6 → busy=0, s=0 next cycle.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision FPU definitions: result constants, rounding-mode
// encodings, operand layout and the helpers used by the sqrt, adder and
// squarer units.
package fp_pkg;

    localparam logic [31:0] ZERO = 32'h0000_0000;
    localparam logic [31:0] INF  = 32'h7f80_0000;
    localparam logic [31:0] NAN  = 32'h7fc0_0000;
    localparam logic [31:0] MAX  = 32'h7f7f_ffff;

    // Radix-4 steps needed to consume a 24-bit multiplier.
    localparam logic [4:0] SQ_ITERS = 5'd12;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RDN = 2'b01,
        RM_RUP = 2'b10,
        RM_RTZ = 2'b11
    } rm_t;

    typedef enum logic [1:0] {
        CLS_NUM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    // Decide whether the truncated magnitude must be bumped by one ulp.
    function automatic logic round_inc(input rm_t  rm,
                                       input logic sign,
                                       input logic lsb,
                                       input logic guard,
                                       input logic sticky);
        logic inc;
        case (rm)
            RM_RNE:  inc = guard & (sticky | lsb);
            RM_RDN:  inc = sign & (guard | sticky);
            RM_RUP:  inc = ~sign & (guard | sticky);
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

    // Leading-zero count of a 24-bit value (result meaningless for v == 0).
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fsquare_iter_square24.sv
// Sequential 24x24 mantissa squarer, two multiplier bits per step.
// Owns the accumulator, iteration counter and busy flag for the squarer.
module square24_radix4
    import fp_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        enable,
    input  logic [23:0] m,
    output logic [47:0] product,
    output logic [4:0]  count,
    output logic        busy
);

    logic [47:0] acc;
    logic [47:0] mcand;
    logic [23:0] mplier;
    logic [47:0] partial;

    // Select 0/1/2/3 times the shifted multiplicand for this step.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        partial = '0;
        case (mplier[1:0])
            2'd1:    partial = mcand;
            2'd2:    partial = mcand << 1;
            2'd3:    partial = mcand + (mcand << 1);
            default: partial = '0;
        endcase
    end

    // Load on start, then accumulate one radix-4 digit per enabled cycle;
    // the cycle after the last digit is the finish cycle that drops busy.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (enable) begin
            if (start) begin
                acc    <= '0;
                mcand  <= {24'd0, m};
                mplier <= m;
                count  <= SQ_ITERS;
                busy   <= 1'b1;
            end else if (busy) begin
                if (count != 5'd0) begin
                    acc    <= acc + partial;
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
                    count  <= count - 5'd1;
                end else begin
                    busy   <= 1'b0;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/fsquare_iter.sv
// Iterative single-precision squarer s = d * d. Unpacks and normalizes the
// operand, runs the radix-4 mantissa squarer, then normalizes, rounds and
// resolves special cases in one finish cycle before writing s.
module fsquare_iter
    import fp_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] d,
    input  logic [1:0]  rm,
    input  logic        fsquare,
    input  logic        enable,
    output logic [31:0] s,
    output logic        busy,
    output logic        stall,
    output logic [4:0]  count
);

    fp32_t            op;
    logic             accept;
    logic             done;
    logic [4:0]       lz;
    logic [23:0]      m_in;
    logic signed [9:0] e_in;
    fp_class_t        cls_in;
    logic             sign_in;

    rm_t              rm_q;
    fp_class_t        cls_q;
    logic signed [9:0] e_q;
    logic             sign_q;
    logic [31:0]      s_q;

    logic [47:0]      product;

    assign op      = d;
    assign accept  = fsquare & enable & ~busy;
    assign done    = busy & enable & (count == 5'd0);
    assign stall   = fsquare & busy;
    assign lz      = lzc24({1'b0, op.frac});
    // A square's sign is the product of two equal signs, hence always positive.
    assign sign_in = op.sign ^ op.sign;

    // Classify the operand and produce a mantissa with its MSB set.
    always_comb begin
        m_in   = {1'b1, op.frac};
        e_in   = $signed({2'b00, op.exp}) - 10'sd127;
        cls_in = CLS_NUM;
        if (op.exp == 8'hff) begin
            cls_in = (op.frac != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (op.exp == 8'h00) begin
            if (op.frac == 23'd0) begin
                cls_in = CLS_ZERO;
            end else begin
                m_in = {1'b0, op.frac} << lz;
                e_in = -10'sd126 - $signed({5'd0, lz});
            end
        end
    end

    square24_radix4 u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (accept),
        .enable  (enable),
        .m       (m_in),
        .product (product),
        .count   (count),
        .busy    (busy)
    );

    logic              norm_up;
    logic [47:0]       pn;
    logic signed [11:0] e2;
    logic signed [11:0] exp_b;
    logic signed [11:0] sh;
    logic [4:0]        sh_amt;
    logic              underflow;
    logic              overflow;
    logic [47:0]       shifted;
    logic              lost;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [7:0]        exp_field;
    logic [31:0]       rounded;
    logic [31:0]       s_next;

    // Normalize the [1,4) product, denormalize on underflow, round, and
    // pick the final encoding.
    always_comb begin
        norm_up   = product[47];
        pn        = norm_up ? product : (product << 1);
        e2        = {e_q[9], e_q, 1'b0};
        exp_b     = e2 + 12'sd127 + {11'd0, norm_up};
        sh        = 12'sd1 - exp_b;
        underflow = (exp_b <= 12'sd0);
        overflow  = (exp_b >= 12'sd255);
        sh_amt    = 5'd0;
        shifted   = pn;
        lost      = 1'b0;
        if (underflow) begin
            if (sh > 12'sd25) begin
                shifted = '0;
                lost    = 1'b1;
            end else begin
                sh_amt  = sh[4:0];
                shifted = pn >> sh_amt;
                lost    = |(pn & ~(48'hffff_ffff_ffff << sh_amt));
            end
        end
        guard  = shifted[23];
        sticky = (|shifted[22:0]) | lost;
        inc    = round_inc(rm_q, sign_q, shifted[24], guard, sticky);
        // For a denormal the exponent field is just the (now cleared) hidden
        // bit, so a rounding carry promotes it to the smallest normal.
        exp_field = underflow ? {7'd0, shifted[47]} : exp_b[7:0];
        rounded   = {sign_q, exp_field, shifted[46:24]} + {31'd0, inc};
        if (overflow) begin
            rounded = (rm_q == RM_RNE || rm_q == RM_RUP) ? INF : MAX;
        end
        case (cls_q)
            CLS_NAN:  s_next = NAN;
            CLS_INF:  s_next = INF;
            CLS_ZERO: s_next = ZERO;
            default:  s_next = rounded;
        endcase
    end

    // Capture operand context on accept; write the result on finish.
    always_ff @(posedge clock) begin
        if (reset) begin
            rm_q   <= RM_RNE;
            cls_q  <= CLS_NUM;
            e_q    <= '0;
            sign_q <= 1'b0;
            s_q    <= '0;
        end else begin
            if (accept) begin
                rm_q   <= rm_t'(rm);
                cls_q  <= cls_in;
                e_q    <= e_in;
                sign_q <= sign_in;
            end
            if (done) begin
                s_q <= s_next;
            end
        end
    end

    assign s = s_q;

endmodule

// File: tb/tb_fsquare_iter.sv
// Self-checking bench for fsquare_iter: directed vectors, handshake, enable
// freeze and reset abort, plus random operands against an exact-arithmetic model.
module tb_fsquare_iter;

    logic        clock;
    logic        reset;
    logic [31:0] d;
    logic [1:0]  rm;
    logic        fsquare;
    logic        enable;
    logic [31:0] s;
    logic        busy;
    logic        stall;
    logic [4:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    fsquare_iter dut (
        .clock   (clock),
        .reset   (reset),
        .d       (d),
        .rm      (rm),
        .fsquare (fsquare),
        .enable  (enable),
        .s       (s),
        .busy    (busy),
        .stall   (stall),
        .count   (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact square as N * 2^q, rounded to the float grid with integer arithmetic.
    function automatic logic [31:0] ref_square(input logic [31:0] x, input logic [1:0] mode);
        logic [7:0]  ef;
        logic [22:0] f;
        longint      mant;
        longint      p;
        longint      n;
        longint      rem;
        longint      half;
        int          ex;
        int          b;
        int          q;
        int          sh;
        bit          gt;
        bit          eq;
        bit          nz;
        bit          up;
        ef = x[30:23];
        f  = x[22:0];
        if (ef == 8'hff) return (f != 23'd0) ? 32'h7fc0_0000 : 32'h7f80_0000;
        if (ef == 8'h00 && f == 23'd0) return 32'h0;
        mant = (ef == 8'h00) ? longint'(f) : ((longint'(1) << 23) | longint'(f));
        ex   = (ef == 8'h00) ? -149 : int'(ef) - 150;
        p    = mant * mant;
        b    = 0;
        for (int i = 0; i < 63; i++) if (p[i]) b = i;
        q = b + 2 * ex - 23;
        if (q < -149) q = -149;
        sh = q - 2 * ex;
        if (sh > 60) begin
            n = 0; gt = 1'b0; eq = 1'b0; nz = 1'b1;
        end else begin
            n    = p >> sh;
            rem  = p - (n << sh);
            half = longint'(1) << (sh - 1);
            gt   = rem > half;
            eq   = rem == half;
            nz   = rem != 0;
        end
        case (mode)
            2'd0:    up = gt || (eq && n[0]);
            2'd2:    up = nz;
            default: up = 1'b0;
        endcase
        if (up) n = n + 1;
        if (n == (longint'(1) << 24)) begin
            n = n >> 1;
            q = q + 1;
        end
        if (n < (longint'(1) << 23)) return {9'd0, n[22:0]};
        if (q + 150 >= 255) return (mode == 2'd0 || mode == 2'd2) ? 32'h7f80_0000 : 32'h7f7f_ffff;
        return {1'b0, 8'(q + 150), n[22:0]};
    endfunction

    // Issue one operation (busy must be low), wait for it, check latency and s.
    task automatic run_op(input logic [31:0] din, input logic [1:0] rmin,
                          input logic [31:0] exp_s, input string tag, input bit chk_cnt);
        int cyc;
        @(negedge clock);
        d = din; rm = rmin; fsquare = 1'b1;
        @(negedge clock);
        fsquare = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            if (chk_cnt) check({tag, "_count"}, 32'(count), 32'(12 - cyc));
            cyc++;
            @(negedge clock);
        end
        check({tag, "_latency"}, 32'(cyc), 32'd13);
        check({tag, "_s"}, s, exp_s);
    endtask

    typedef struct {
        logic [31:0] d;
        logic [1:0]  rm;
        logic [31:0] s;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic [31:0] rd;
        logic [1:0]  rrm;
        logic [7:0]  ef;

        vecs = '{
            '{32'h3fc0_0000, 2'd0, 32'h4010_0000},
            '{32'h3f80_0001, 2'd0, 32'h3f80_0002},
            '{32'h3f80_0001, 2'd2, 32'h3f80_0003},
            '{32'h3f80_0001, 2'd3, 32'h3f80_0002},
            '{32'hc040_0000, 2'd0, 32'h4110_0000},
            '{32'h1f80_0000, 2'd0, 32'h0020_0000},
            '{32'h7f7f_ffff, 2'd0, 32'h7f80_0000},
            '{32'h7f7f_ffff, 2'd3, 32'h7f7f_ffff},
            '{32'h0000_0001, 2'd0, 32'h0000_0000},
            '{32'h0000_0001, 2'd2, 32'h0000_0001},
            '{32'hffc0_0000, 2'd0, 32'h7fc0_0000},
            '{32'hff80_0000, 2'd0, 32'h7f80_0000},
            '{32'h8000_0000, 2'd0, 32'h0000_0000}
        };

        reset = 1'b1; fsquare = 1'b0; enable = 1'b1; d = '0; rm = '0;
        repeat (3) @(negedge clock);
        check("rst_s", s, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].d, vecs[i].rm, vecs[i].s, $sformatf("dir%0d", i), i == 0);

        // Request held during busy: stalls, then second op accepted at T+14.
        @(negedge clock);
        d = 32'h3fc0_0000; rm = 2'd0; fsquare = 1'b1;
        @(negedge clock);
        d = 32'hc040_0000;
        cyc = 0;
        while (busy && cyc < 40) begin
            check("hs_stall", 32'(stall), 32'd1);
            cyc++;
            @(negedge clock);
        end
        check("hs_latency_a", 32'(cyc), 32'd13);
        check("hs_s_a", s, 32'h4010_0000);
        check("hs_stall_idle", 32'(stall), 32'd0);
        @(negedge clock);
        fsquare = 1'b0;
        check("hs_busy_b", 32'(busy), 32'd1);
        check("hs_count_b", 32'(count), 32'd12);
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clock);
        end
        check("hs_latency_b", 32'(cyc), 32'd13);
        check("hs_s_b", s, 32'h4110_0000);

        // Enable low during T+5..T+7 freezes the count and stretches latency by 3.
        @(negedge clock);
        d = 32'h3f80_0001; rm = 2'd2; fsquare = 1'b1;
        @(negedge clock);
        fsquare = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            check("en_count", 32'(count),
                  32'((cyc <= 4) ? 12 - cyc : (cyc <= 7) ? 8 : 15 - cyc));
            enable = (cyc >= 4 && cyc <= 6) ? 1'b0 : 1'b1;
            cyc++;
            @(negedge clock);
        end
        enable = 1'b1;
        check("en_latency", 32'(cyc), 32'd16);
        check("en_s", s, 32'h3f80_0003);

        // Reset in T+6 aborts the operation and clears s.
        @(negedge clock);
        d = 32'h4000_0000; rm = 2'd0; fsquare = 1'b1;
        @(negedge clock);
        fsquare = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_s", s, 32'h0);
        check("rstmid_count", 32'(count), 32'd0);
        repeat (20) @(negedge clock);
        check("rstmid_no_result", s, 32'h0);

        // Random operands biased toward underflow, overflow and denormals.
        for (int i = 0; i < 300; i++) begin
            rd  = $urandom;
            rrm = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: ef = rd[30:23];
                1: ef = 8'h00;
                2: ef = 8'($urandom_range(55, 70));
                3: ef = 8'($urandom_range(185, 200));
                4: ef = 8'($urandom_range(100, 150));
                default: ef = ($urandom_range(0, 1) == 1) ? 8'hff : 8'h00;
            endcase
            rd[30:23] = ef;
            if ($urandom_range(0, 7) == 0) rd[22:0] = 23'($urandom_range(0, 3));
            run_op(rd, rrm, ref_square(rd, rrm), $sformatf("rnd%0d_%h_rm%0d", i, rd, rrm), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
